// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS key controller: key bit positions, waveform codes,
// controller FSM states and the frequency step table.
package dds_ctrl_pkg;

  localparam int N_KEYS   = 4;
  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
  localparam int KEY_STEP = 2;
  localparam int KEY_WAVE = 3;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_TRI    = 2'd1;
  localparam logic [1:0] WAVE_SQUARE = 2'd2;

  localparam logic [2:0] STEP_IDX_MAX = 3'd6;
  localparam int         STEP_TAB_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_e;

  // Decade step table; indices past the end fall back to the smallest step.
  function automatic logic [STEP_TAB_W-1:0] step_of(input logic [2:0] idx);
    case (idx)
      3'd0:    step_of = 32'd1;
      3'd1:    step_of = 32'd10;
      3'd2:    step_of = 32'd100;
      3'd3:    step_of = 32'd1_000;
      3'd4:    step_of = 32'd10_000;
      3'd5:    step_of = 32'd100_000;
      3'd6:    step_of = 32'd1_000_000;
      default: step_of = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/dds_key_repeat.sv
// Long-press auto-repeat timer: one tick after HOLD_CYC cycles held, then one tick
// every REPEAT_CYC cycles until the key is released.
module dds_key_repeat #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic press_i,
  input  logic release_i,
  output logic tick_o
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  // The counter tops out at HOLD_CYC-1; re-arming below that gives the repeat period.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_REARM = CNT_W'(HOLD_CYC - REPEAT_CYC);

  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (press_i) begin
      held_d = 1'b1;
      cnt_d  = '0;
    end else if (release_i) begin
      held_d = 1'b0;
      cnt_d  = '0;
    end else if (held_q) begin
      if (cnt_q == CNT_LAST) begin
        tick_o = 1'b1;
        cnt_d  = CNT_REARM;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// Key-driven DDS settings controller: edits frequency/step/waveform from key events
// and pushes each committed setting to the DDS writer over valid/ready.
module dds_key_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int FREQ_W     = 32,
  parameter int FREQ_MIN   = 1,
  parameter int FREQ_MAX   = 10_000_000,
  parameter int FREQ_INIT  = 1_000,
  parameter int STEP_INIT  = 3,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_flag,
  input  logic [N_KEYS-1:0] key_state,
  input  logic              cfg_ready,
  output logic              cfg_valid,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [1:0]        wave_sel,
  output logic [2:0]        step_idx
);

  localparam int              FW1   = FREQ_W + 1;
  localparam logic [FW1-1:0]  MAX_W = FW1'(FREQ_MAX);
  localparam logic [FW1-1:0]  MIN_W = FW1'(FREQ_MIN);

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] work_freq_q, work_freq_d;
  logic [1:0]        work_wave_q, work_wave_d;
  logic [2:0]        step_q, step_d;
  logic              dirty_q, dirty_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [1:0]        wave_q, wave_d;

  logic [N_KEYS-1:0] press_ev, release_ev;
  logic              up_tick, dn_tick, do_up, do_dn;
  logic              dirty_set, load;
  logic [FW1-1:0]    step_val, sum, diff;

  assign press_ev   = key_flag & ~key_state;
  assign release_ev = key_flag &  key_state;

  dds_key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_up (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .press_i   (press_ev[KEY_UP]),
    .release_i (release_ev[KEY_UP]),
    .tick_o    (up_tick)
  );

  dds_key_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_rep_dn (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .press_i   (press_ev[KEY_DN]),
    .release_i (release_ev[KEY_DN]),
    .tick_o    (dn_tick)
  );

  assign do_up    = press_ev[KEY_UP] | up_tick;
  assign do_dn    = press_ev[KEY_DN] | dn_tick;
  assign step_val = FW1'(step_of(step_q));
  assign sum      = {1'b0, work_freq_q} + step_val;
  assign diff     = {1'b0, work_freq_q} - step_val;

  // Key actions, one per cycle in priority order UP > DN > STEP > WAVE.
  always_comb begin
    work_freq_d = work_freq_q;
    work_wave_d = work_wave_q;
    step_d      = step_q;
    dirty_set   = 1'b0;
    if (do_up) begin
      work_freq_d = (sum > MAX_W) ? MAX_W[FREQ_W-1:0] : sum[FREQ_W-1:0];
      dirty_set   = 1'b1;
    end else if (do_dn) begin
      // A set top bit means the subtraction went below zero.
      work_freq_d = (diff[FREQ_W] || diff < MIN_W) ? MIN_W[FREQ_W-1:0] : diff[FREQ_W-1:0];
      dirty_set   = 1'b1;
    end else if (press_ev[KEY_STEP]) begin
      step_d = (step_q == STEP_IDX_MAX) ? 3'd0 : step_q + 3'd1;
    end else if (press_ev[KEY_WAVE]) begin
      case (work_wave_q)
        WAVE_SINE: work_wave_d = WAVE_TRI;
        WAVE_TRI:  work_wave_d = WAVE_SQUARE;
        default:   work_wave_d = WAVE_SINE;
      endcase
      dirty_set = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (dirty_q) state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: if (cfg_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An edit landing in the LOAD cycle must trigger a follow-up transfer.
    dirty_d = dirty_set | (dirty_q & ~load);
    freq_d  = load ? work_freq_q : freq_q;
    wave_d  = load ? work_wave_q : wave_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_freq_q <= FREQ_W'(FREQ_INIT);
      work_wave_q <= WAVE_SINE;
      step_q      <= 3'(STEP_INIT);
      dirty_q     <= 1'b1;
      freq_q      <= FREQ_W'(FREQ_INIT);
      wave_q      <= WAVE_SINE;
    end else begin
      state_q     <= state_d;
      work_freq_q <= work_freq_d;
      work_wave_q <= work_wave_d;
      step_q      <= step_d;
      dirty_q     <= dirty_d;
      freq_q      <= freq_d;
      wave_q      <= wave_d;
    end
  end

  assign cfg_valid = (state_q == ST_SEND);
  assign freq_hz   = freq_q;
  assign wave_sel  = wave_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Self-checking bench for dds_key_ctrl: directed scenarios plus random key bursts,
// compared against an arithmetic model of the key rules.
module tb_dds_key_ctrl;

  localparam longint F_MAX  = 10_000_000;
  localparam longint F_MIN  = 1;
  localparam logic [3:0] K_UP = 4'b0001, K_DN = 4'b0010, K_STEP = 4'b0100, K_WAVE = 4'b1000;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [3:0]  key_flag, key_state;
  logic        cfg_ready, cfg_valid;
  logic [31:0] freq_hz;
  logic [1:0]  wave_sel;
  logic [2:0]  step_idx;

  int n_cmp = 0;
  int n_err = 0;

  int          xfer_cnt = 0;
  logic [1:0]  last_wave = 2'd0;

  longint m_freq;
  int     m_wave, m_step;

  dds_key_ctrl #(.HOLD_CYC(20), .REPEAT_CYC(5)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .key_flag  (key_flag),
    .key_state (key_state),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .freq_hz   (freq_hz),
    .wave_sel  (wave_sel),
    .step_idx  (step_idx)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (!rst && cfg_valid && cfg_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_wave <= wave_sel;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint decade(input int idx);
    longint s = 1;
    for (int i = 0; i < idx; i++) s = s * 10;
    return s;
  endfunction

  // One acting press: the lowest set bit wins.
  task automatic model_press(input logic [3:0] ev);
    if (ev[0])      m_freq = (m_freq + decade(m_step) > F_MAX) ? F_MAX : m_freq + decade(m_step);
    else if (ev[1]) m_freq = (m_freq - decade(m_step) < F_MIN) ? F_MIN : m_freq - decade(m_step);
    else if (ev[2]) m_step = (m_step + 1) % 7;
    else if (ev[3]) m_wave = (m_wave + 1) % 3;
  endtask

  task automatic model_reset();
    m_freq = 1000;
    m_wave = 0;
    m_step = 3;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press(input logic [3:0] ev);
    key_flag  = ev;
    key_state = ~ev;
    model_press(ev);
    @(negedge sys_clk);
    key_flag = 4'b0;
  endtask

  task automatic release_keys(input logic [3:0] ev);
    key_flag  = ev;
    key_state = 4'hF;
    @(negedge sys_clk);
    key_flag = 4'b0;
  endtask

  task automatic tap(input logic [3:0] ev);
    press(ev);
    release_keys(ev);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_freq"}, 64'(freq_hz), 64'(m_freq));
    check({tag, "_wave"}, 64'(wave_sel), 64'(m_wave));
    check({tag, "_step"}, 64'(step_idx), 64'(m_step));
  endtask

  initial begin
    int x0;
    logic [3:0] ev;
    rst = 1'b1; cfg_ready = 1'b0; key_flag = 4'b0; key_state = 4'hF;
    model_reset();
    cycles(2);
    check("rst_valid", 64'(cfg_valid), 64'd0);
    check_model("rst");

    // 1: initial setting pushed, held while cfg_ready is low
    rst = 1'b0;
    cycles(10);
    check("t1_valid_held", 64'(cfg_valid), 64'd1);
    check("t1_freq", 64'(freq_hz), 64'd1000);
    check("t1_wave", 64'(wave_sel), 64'd0);
    cfg_ready = 1'b1;
    cycles(1);
    check("t1_valid_drop", 64'(cfg_valid), 64'd0);
    check("t1_xfers", 64'(xfer_cnt), 64'd1);

    // 2: UP press, latency N+3, single transfer
    x0 = xfer_cnt;
    press(K_UP);
    check("t2_n1_valid", 64'(cfg_valid), 64'd0);
    cycles(1);
    check("t2_n2_valid", 64'(cfg_valid), 64'd0);
    cycles(1);
    check("t2_n3_valid", 64'(cfg_valid), 64'd1);
    check("t2_n3_freq", 64'(freq_hz), 64'd2000);
    release_keys(K_UP);
    cycles(30);
    check("t2_xfers", 64'(xfer_cnt - x0), 64'd1);
    check_model("t2");

    // 3: STEP wraps 3->0 without transfers, then DN by 1
    tap(K_DN);
    cycles(6);
    check("t3_freq1000", 64'(freq_hz), 64'd1000);
    x0 = xfer_cnt;
    repeat (4) tap(K_STEP);
    check("t3_step", 64'(step_idx), 64'd0);
    cycles(6);
    check("t3_no_xfer", 64'(xfer_cnt - x0), 64'd0);
    tap(K_DN);
    cycles(6);
    check("t3_freq999", 64'(freq_hz), 64'd999);
    check_model("t3");

    // 4: saturation at both ends
    repeat (6) tap(K_STEP);
    repeat (10) tap(K_UP);
    cycles(6);
    check("t4_sat_a", 64'(freq_hz), 64'd10_000_000);
    repeat (3) tap(K_STEP);
    repeat (5) tap(K_DN);
    cycles(6);
    check("t4_9999500", 64'(freq_hz), 64'd9_999_500);
    repeat (4) tap(K_STEP);
    tap(K_UP);
    cycles(6);
    check("t4_sat_max", 64'(freq_hz), 64'd10_000_000);
    check_model("t4a");
    repeat (10) tap(K_DN);
    tap(K_STEP);
    repeat (4) tap(K_UP);
    tap(K_STEP);
    cycles(6);
    check("t4_freq5", 64'(freq_hz), 64'd5);
    tap(K_DN);
    cycles(6);
    check("t4_sat_min", 64'(freq_hz), 64'd1);
    check_model("t4b");

    // 5: UP held 40 cycles -> press + 4 repeat ticks
    x0 = xfer_cnt;
    press(K_UP);
    cycles(39);
    repeat (4) model_press(K_UP);
    release_keys(K_UP);
    cycles(6);
    check("t5_xfers", 64'(xfer_cnt - x0), 64'd5);
    check_model("t5");
    cycles(30);
    check("t5_after_rel", 64'(xfer_cnt - x0), 64'd5);

    // 6: priority and coalescing while stalled
    x0 = xfer_cnt;
    press(K_UP | K_WAVE);
    release_keys(K_UP | K_WAVE);
    cycles(6);
    check("t6_wave_kept", 64'(wave_sel), 64'd0);
    check("t6_xfers", 64'(xfer_cnt - x0), 64'd1);
    check_model("t6a");
    cfg_ready = 1'b0;
    x0 = xfer_cnt;
    repeat (3) tap(K_WAVE);
    cycles(4);
    check("t6_stall_valid", 64'(cfg_valid), 64'd1);
    check("t6_stall_wave", 64'(wave_sel), 64'd1);
    check("t6_stall_xfers", 64'(xfer_cnt - x0), 64'd0);
    cfg_ready = 1'b1;
    cycles(8);
    check("t6_coalesced", 64'(xfer_cnt - x0), 64'd2);
    check("t6_last_wave", 64'(last_wave), 64'd0);
    check_model("t6b");

    // random key bursts, released one cycle later
    for (int i = 0; i < 24; i++) begin
      ev = 4'($urandom_range(1, 15));
      press(ev);
      release_keys(ev);
      cycles(5);
      check_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset in the middle of a stalled handshake
    cfg_ready = 1'b0;
    tap(K_WAVE);
    cycles(3);
    check("ar_valid_pre", 64'(cfg_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_drop", 64'(cfg_valid), 64'd0);
    model_reset();
    check_model("ar");
    @(negedge sys_clk);
    rst = 1'b0;
    x0 = xfer_cnt;
    cfg_ready = 1'b1;
    cycles(6);
    check("ar_repush", 64'(xfer_cnt - x0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
